// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment digit scan controller with frame-aligned value loading
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    output logic [3:0]                dig_code,
    output logic                      dig_blank,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      scan_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } stateT;

    stateT                   state, stateNext;
    logic [IW-1:0]           idx, idxNext;
    logic [CW-1:0]           cnt, cntNext;
    logic [4*NUM_DIGITS-1:0] display, displayNext;
    logic [4*NUM_DIGITS-1:0] pendData, pendDataNext;
    logic                    pendValid, pendValidNext;
    logic                    frameWrap;
    logic [3:0]              nibble;
    logic                    upperZero;

    logic [NUM_DIGITS-1:0]   anNNext;
    logic [3:0]              digCodeNext;
    logic                    digBlankNext;
    logic                    scanTickNext;
    logic                    loadReadyNext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            display    <= '0;
            pendData   <= '0;
            pendValid  <= 1'b0;
            an_n       <= '1;
            dig_code   <= 4'd0;
            dig_blank  <= 1'b1;
            scan_tick  <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            cnt        <= cntNext;
            display    <= displayNext;
            pendData   <= pendDataNext;
            pendValid  <= pendValidNext;
            an_n       <= anNNext;
            dig_code   <= digCodeNext;
            dig_blank  <= digBlankNext;
            scan_tick  <= scanTickNext;
            load_ready <= loadReadyNext;
        end
    end

    always_comb begin
        stateNext     = state;
        idxNext       = idx;
        cntNext       = cnt;
        displayNext   = display;
        pendDataNext  = pendData;
        pendValidNext = pendValid;
        frameWrap     = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    stateNext = GUARD;
                    idxNext   = '0;
                    cntNext   = '0;
                end
            end
            GUARD: begin
                stateNext = DRIVE;
                cntNext   = CW'(1);
            end
            DRIVE: begin
                if (cnt == CNT_LAST) begin
                    cntNext   = '0;
                    stateNext = GUARD;
                    if (idx == IDX_LAST) begin
                        idxNext   = '0;
                        frameWrap = 1'b1;
                    end else begin
                        idxNext = idx + 1'b1;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (!enable) begin
            stateNext = IDLE;
            idxNext   = '0;
            cntNext   = '0;
            frameWrap = 1'b0;
        end

        // load_ready mirrors !pendValid, so apply and transfer never coincide
        if (pendValid && (frameWrap || state == IDLE)) begin
            displayNext   = pendData;
            pendValidNext = 1'b0;
        end else if (load_valid && load_ready) begin
            pendDataNext  = load_data;
            pendValidNext = 1'b1;
        end

        // Outputs are registered from next-cycle values so they line up with the held state
        nibble    = displayNext[4*idxNext +: 4];
        upperZero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idxNext) && displayNext[4*i +: 4] != 4'd0) begin
                upperZero = 1'b0;
            end
        end

        anNNext       = '1;
        digCodeNext   = 4'd0;
        digBlankNext  = 1'b1;
        scanTickNext  = 1'b0;
        loadReadyNext = !pendValidNext;

        case (stateNext)
            GUARD: scanTickNext = 1'b1;
            DRIVE: begin
                anNNext[idxNext] = 1'b0;
                digCodeNext      = nibble;
                digBlankNext     = (nibble > 4'd9) || (LZ_BLANK && idxNext != '0 && upperZero);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized and directed bench for seg_scan_ctrl against a frame-phase model
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int FRAME = N * S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        load_ready;
    logic [3:0]  dig_code;
    logic        dig_blank;
    logic [3:0]  an_n;
    logic        scan_tick;

    int checks = 0;
    int passes = 0;

    // Model: scanning is a phase counter within a frame; digit and slot position follow by division
    bit          mRun = 1'b0;
    int          mPhase = 0;
    logic [15:0] mDisp = 16'h0;
    logic [15:0] mPend = 16'h0;
    bit          mPendValid = 1'b0;
    logic [15:0] xferLog[$];

    seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .LZ_BLANK(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dig_code   (dig_code),
        .dig_blank  (dig_blank),
        .an_n       (an_n),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    endtask

    task automatic modelEdge(input bit vRst, input bit vEn, input bit vValid, input logic [15:0] vData);
        bit xfer, wrap, idleBefore;
        if (!vRst) begin
            mRun = 0; mPhase = 0; mDisp = 16'h0; mPend = 16'h0; mPendValid = 0;
        end else begin
            xfer       = vValid && !mPendValid;
            idleBefore = !mRun;
            wrap       = mRun && vEn && (mPhase == FRAME - 1);
            if (mPendValid && (wrap || idleBefore)) begin
                mDisp = mPend; mPendValid = 0;
            end else if (xfer) begin
                mPend = vData; mPendValid = 1;
            end
            if (!vEn) begin
                mRun = 0; mPhase = 0;
            end else if (!mRun) begin
                mRun = 1; mPhase = 0;
            end else begin
                mPhase = (mPhase + 1) % FRAME;
            end
        end
    endtask

    task automatic checkOutputs();
        int dig, pos;
        logic [3:0] nib, eAn, eCode;
        logic eBlank, eTick;
        eAn = 4'hF; eCode = 4'h0; eBlank = 1'b1; eTick = 1'b0;
        if (mRun) begin
            dig = mPhase / S;
            pos = mPhase % S;
            if (pos == 0) begin
                eTick = 1'b1;
            end else begin
                nib    = 4'((mDisp >> (4 * dig)) & 16'hF);
                eAn    = ~(4'b0001 << dig);
                eCode  = nib;
                eBlank = (nib > 4'd9) || (dig > 0 && (mDisp >> (4 * dig)) == 16'h0);
            end
        end
        chk("an_n", 32'(an_n), 32'(eAn));
        chk("dig_code", 32'(dig_code), 32'(eCode));
        chk("dig_blank", 32'(dig_blank), 32'(eBlank));
        chk("scan_tick", 32'(scan_tick), 32'(eTick));
        chk("load_ready", 32'(load_ready), 32'(!mPendValid));
    endtask

    task automatic step();
        bit vRst, vEn, vValid;
        logic [15:0] vData;
        vRst = rst_n; vEn = enable; vValid = load_valid; vData = load_data;
        if (vRst && vValid && load_ready === 1'b1) xferLog.push_back(vData);
        @(posedge clk);
        modelEdge(vRst, vEn, vValid, vData);
        #1;
        checkOutputs();
    endtask

    task automatic loadValue(input logic [15:0] v, input bit keep);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = v;
        while (load_ready !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        chk("load_wait_bound", 32'(n < 64), 32'd1);
        step();
        if (!keep) load_valid = 1'b0;
    endtask

    task automatic waitDrive(input int d);
        int n;
        n = 0;
        while (!(mRun && (mPhase % S) != 0 && (d < 0 || (mPhase / S) == d)) && n < 64) begin
            step();
            n++;
        end
        chk("drive_wait_bound", 32'(n < 64), 32'd1);
    endtask

    function automatic logic [15:0] randVal();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0: randVal = r;
            1: randVal = r & 16'h0FFF;
            2: randVal = r & 16'h00FF;
            default: randVal = r & 16'h000F;
        endcase
    endfunction

    initial begin
        bit xfer;

        // reset state and idle with enable low
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();

        // load 1234 in idle, then scan two frames
        loadValue(16'h1234, 1'b0);
        step();
        enable = 1'b1;
        repeat (2 * FRAME) step();

        // mid-frame load at digit 1 applies only at the frame wrap
        waitDrive(1);
        loadValue(16'h0567, 1'b0);
        repeat (2 * FRAME) step();

        // invalid BCD on digit 0 with leading zeros above it
        loadValue(16'h000A, 1'b0);
        repeat (2 * FRAME + 4) step();

        // two back-to-back values with valid held high
        xferLog.delete();
        loadValue(16'h4321, 1'b1);
        loadValue(16'h8765, 1'b0);
        repeat (2 * FRAME) step();
        chk("xfer_count", 32'(xferLog.size()), 32'd2);
        chk("xfer_first", 32'(xferLog.size() > 0 ? xferLog[0] : 16'hxxxx), 32'h4321);
        chk("xfer_second", 32'(xferLog.size() > 1 ? xferLog[1] : 16'hxxxx), 32'h8765);

        // enable drop mid-drive, then reset with a pending value
        waitDrive(-1);
        enable = 1'b0;
        step();
        chk("an_n_after_disable", 32'(an_n), 32'hF);
        repeat (3) step();
        enable = 1'b1;
        waitDrive(-1);
        loadValue(16'h9876, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2 * FRAME) step();

        // randomized traffic
        enable = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 19) == 0) enable = !enable;
            rst_n = ($urandom_range(0, 99) != 0);
            if (!load_valid && $urandom_range(0, 3) == 0) begin
                load_valid = 1'b1;
                load_data  = randVal();
            end
            xfer = load_valid && (load_ready === 1'b1) && rst_n;
            step();
            if (xfer) load_valid = 1'b0;
        end
        rst_n = 1'b1;
        load_valid = 1'b0;
        repeat (FRAME) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
